// File: rtl/counter_out_checker.sv
// counter_out_checker: observer for a WIDTH-bit up-counter, compares each sample against the rule.
// Define COUNTER_CHK_WRAP_EN to build the wrap event counter; otherwise wrap_cnt is tied to 0.
module counter_out_checker #(
    parameter int WIDTH      = 4,
    parameter int ERR_CNT_W  = 8,
    parameter int CHK_CNT_W  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 rst_h,
    input  logic                 check_en,
    input  logic                 dut_rst_h,
    input  logic [WIDTH-1:0]     dut_out,
    output logic                 synced,
    output logic                 err_valid,
    input  logic                 err_ready,
    output logic [WIDTH-1:0]     err_exp,
    output logic [WIDTH-1:0]     err_act,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [CHK_CNT_W-1:0] chk_cnt,
    output logic                 overflow,
    output logic [7:0]           wrap_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SYNC  = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;
    logic [1:0]       state;
    logic             r1, r2;
    logic [WIDTH-1:0] o1, o2;
    logic [WIDTH-1:0] exp_val;
    logic             cmp, mis, push, pop, full, empty;
    logic [WIDTH-1:0] fifo_exp [FIFO_DEPTH];
    logic [WIDTH-1:0] fifo_act [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    // o1 is the newest sample, r2/o2 the one before it that predicts o1
    assign exp_val   = r2 ? '0 : o2 + WIDTH'(1);
    assign cmp       = state == CHECK && check_en;
    assign mis       = cmp && o1 != exp_val;
    assign empty     = count == '0;
    assign full      = count == (AW+1)'(FIFO_DEPTH);
    assign pop       = !empty && err_ready;
    assign push      = mis && (!full || pop);
    assign synced    = state == CHECK;
    assign err_valid = !empty;
    assign err_exp   = empty ? '0 : fifo_exp[rd_ptr];
    assign err_act   = empty ? '0 : fifo_act[rd_ptr];
    always_ff @(posedge clock) begin
        if (rst_h) begin
            state    <= IDLE;
            r1       <= 1'b0;
            r2       <= 1'b0;
            o1       <= '0;
            o2       <= '0;
            err_cnt  <= '0;
            chk_cnt  <= '0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state <= !check_en ? IDLE : state == IDLE ? SYNC : (state == SYNC && r1) ? CHECK : state;
            r1    <= dut_rst_h;
            o1    <= dut_out;
            r2    <= r1;
            o2    <= o1;
            if (cmp && !(&chk_cnt))
                chk_cnt <= chk_cnt + CHK_CNT_W'(1);
            if (mis && !(&err_cnt))
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            if (mis && full && !pop)
                overflow <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_exp[wr_ptr] <= exp_val;
            fifo_act[wr_ptr] <= o1;
        end
    end
`ifdef COUNTER_CHK_WRAP_EN
    always_ff @(posedge clock) begin
        if (rst_h)
            wrap_cnt <= '0;
        else if (cmp && !mis && !r2 && (&o2) && !(&wrap_cnt))
            wrap_cnt <= wrap_cnt + 8'd1;
    end
`else
    assign wrap_cnt = '0;
`endif
endmodule
